vga_timing_gen: RTL

- Parametrised VGA timing generator and pixel output stage, successor to the fixed 640x480 driver.
- Generates hsync/vsync with configurable timing and polarity, plus a registered data-enable.
- Issues per-pixel coordinate requests one cycle ahead and registers the returned colour so colour, sync and DE leave aligned.
- Sits between the frame-buffer/pattern logic and the board DAC pins.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared defaults and helpers for the VGA timing generator.
// Holds 640x480@60 timing, colour field widths, the counter type and the axis-total function.
// No logic; imported by the interface, the axis counter and the top.
package vga_pkg;
   localparam int CNT_W         = 10;
   localparam int CNT_MAX_TOTAL = 1 << CNT_W;

   typedef logic [CNT_W-1:0] cnt_t;

   // 640x480@60 with a 25 MHz pixel clock
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // RGB332 DAC
   localparam int R_W_DEF = 3;
   localparam int G_W_DEF = 3;
   localparam int B_W_DEF = 2;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request bus towards the frame buffer and sync/colour bus towards the DAC.
// master = timing generator (drives requests, syncs, colour); slave = pattern/frame-buffer + DAC side.
// pix_color is returned combinationally in the same cycle as req_x/req_y.
interface vga_timing_gen_if
   import vga_pkg::*;
#(
   parameter int R_W = R_W_DEF,
   parameter int G_W = G_W_DEF,
   parameter int B_W = B_W_DEF
);
   cnt_t                   req_x;
   cnt_t                   req_y;
   logic                   req_valid;
   logic [R_W+G_W+B_W-1:0] pix_color;
   logic                   hsync;
   logic                   vsync;
   logic                   de;
   logic [R_W-1:0]         red;
   logic [G_W-1:0]         green;
   logic [B_W-1:0]         blue;
   logic                   frame_start;
   logic                   line_start;

   modport master (
      output req_x, req_y, req_valid,
      input  pix_color,
      output hsync, vsync, de, red, green, blue, frame_start, line_start
   );

   modport slave (
      input  req_x, req_y, req_valid,
      output pix_color,
      input  hsync, vsync, de, red, green, blue, frame_start, line_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (active, front porch, sync, back porch), counting 0..TOTAL-1.
// Latency: count_o is the register; active_o/in_sync_o/wrap_o decode it combinationally.
// Backpressure: advances only when tick_i && wrap_in_i; otherwise holds.
// Ports: clk_i, rst_ni (sync, active-low), tick_i (step request), wrap_in_i (enable),
//        count_o, active_o, in_sync_o, wrap_o (count at its last value).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic wrap_in_i,
   output cnt_t count_o,
   output logic active_o,
   output logic in_sync_o,
   output logic wrap_o
);
   localparam int   TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam cnt_t LAST     = cnt_t'(TOTAL - 1);
   localparam cnt_t ACT_END  = cnt_t'(ACTIVE);
   localparam cnt_t SYNC_BEG = cnt_t'(ACTIVE + FP);
   localparam cnt_t SYNC_END = cnt_t'(ACTIVE + FP + SYNC);

   if (TOTAL > CNT_MAX_TOTAL) begin : g_total_too_big
      $error("vga_axis_counter: total %0d does not fit the counter", TOTAL);
   end

   cnt_t count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (tick_i && wrap_in_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign active_o  = (count_q < ACT_END);
   assign in_sync_o = (count_q >= SYNC_BEG) && (count_q < SYNC_END);
   assign wrap_o    = (count_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and pixel output stage; requests pixel colour one cycle ahead.
// Latency: 1 cycle from request (req_x/req_y) to aligned hsync/vsync/de/colour/pulses.
// Backpressure: en=0 freezes counters and every output register.
// Ports: clk25MHz, rst (sync, active-low), en, vga (master modport: requests out, pix_color in,
//        syncs/de/colour/frame_start/line_start out); pattern_sel only with VGA_TEST_PATTERN_EN.
// Macro VGA_TEST_PATTERN_EN adds pattern_sel, which swaps pix_color for 8 vertical colour bars.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int R_W      = R_W_DEF,
   parameter int G_W      = G_W_DEF,
   parameter int B_W      = B_W_DEF
) (
   input logic                 clk25MHz,
   input logic                 rst,
   input logic                 en,
`ifdef VGA_TEST_PATTERN_EN
   input logic                 pattern_sel,
`endif
   vga_timing_gen_if.master    vga
);
   localparam int PIX_W = R_W + G_W + B_W;

   cnt_t h_cnt, v_cnt;
   logic h_act, h_sync, h_wrap;
   logic v_act, v_sync, v_wrap_unused;
   logic req_valid;

   vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
      .clk_i     (clk25MHz),
      .rst_ni    (rst),
      .tick_i    (1'b1),
      .wrap_in_i (en),
      .count_o   (h_cnt),
      .active_o  (h_act),
      .in_sync_o (h_sync),
      .wrap_o    (h_wrap)
   );

   // Lines step on the last pixel of each line.
   vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
      .clk_i     (clk25MHz),
      .rst_ni    (rst),
      .tick_i    (h_wrap),
      .wrap_in_i (en),
      .count_o   (v_cnt),
      .active_o  (v_act),
      .in_sync_o (v_sync),
      .wrap_o    (v_wrap_unused)
   );

   assign req_valid     = h_act && v_act;
   assign vga.req_x     = h_cnt;
   assign vga.req_y     = v_cnt;
   assign vga.req_valid = req_valid;

   logic [PIX_W-1:0] color_src;

`ifdef VGA_TEST_PATTERN_EN
   // Bar index = (x*8)/H_ACTIVE; only meaningful inside the active area, masked elsewhere.
   localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W+3)'(H_ACTIVE);
   logic [CNT_W+2:0] bar_num;
   logic [2:0]       bar;
   logic [PIX_W-1:0] pattern;

   assign bar_num   = {h_cnt, 3'b000};
   assign bar       = 3'(bar_num / BAR_DIV);
   assign pattern   = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
   assign color_src = pattern_sel ? pattern : vga.pix_color;
`else
   assign color_src = vga.pix_color;
`endif

   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic [PIX_W-1:0] color_q, color_d;
   logic             frame_start_q, frame_start_d;
   logic             line_start_q, line_start_d;

   assign hsync_d       = h_sync ? HS_POL : ~HS_POL;
   assign vsync_d       = v_sync ? VS_POL : ~VS_POL;
   assign de_d          = req_valid;
   assign color_d       = req_valid ? color_src : '0;
   assign frame_start_d = req_valid && (h_cnt == '0) && (v_cnt == '0);
   assign line_start_d  = req_valid && (h_cnt == '0);

   always_ff @(posedge clk25MHz) begin
      if (!rst) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         de_q          <= 1'b0;
         color_q       <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else if (en) begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         color_q       <= color_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.de          = de_q;
   assign vga.red         = color_q[PIX_W-1 -: R_W];
   assign vga.green       = color_q[B_W +: G_W];
   assign vga.blue        = color_q[0 +: B_W];
   assign vga.frame_start = frame_start_q;
   assign vga.line_start  = line_start_q;
endmodule
